// File: rtl/truth_table_sweeper.sv
// Self-timed truth-table sweeper: drives every input vector, holds it, captures y per vector.
// Optional TT_SWEEP_GRAY_EN applies vectors in Gray-code order instead of binary ascending.
module truth_table_sweeper #(
    parameter int N_IN         = 3,
    parameter int DWELL_CYCLES = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic [N_IN-1:0]      o_vec,
    input  logic                 i_y,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_truth_table
);

    localparam int NV = 2**N_IN;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DW-1:0]     r_dwell, w_dwell_nxt;
    logic [N_IN-1:0]   r_step,  w_step_nxt;
    logic [N_IN-1:0]   r_vec,   w_vec_nxt;
    logic [NV-1:0]     r_tt,    w_tt_nxt;
    logic [N_IN-1:0]   w_step_inc;
    logic [N_IN-1:0]   w_vec_inc;
    logic              w_dwell_tc;
    logic              w_last;

    assign w_step_inc = r_step + N_IN'(1);
`ifdef TT_SWEEP_GRAY_EN
    assign w_vec_inc  = w_step_inc ^ (w_step_inc >> 1);
`else
    assign w_vec_inc  = w_step_inc;
`endif
    assign w_dwell_tc = (r_dwell == DW'(DWELL_CYCLES - 1));
    assign w_last     = (r_step == N_IN'(NV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
            r_step  <= '0;
            r_vec   <= '0;
            r_tt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_step  <= w_step_nxt;
            r_vec   <= w_vec_nxt;
            r_tt    <= w_tt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_step_nxt  = r_step;
        w_vec_nxt   = r_vec;
        w_tt_nxt    = r_tt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_tt_nxt    = '0;
                    w_vec_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_step_nxt  = '0;
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                // Capture on the last dwell cycle, indexed by the applied vector.
                if (w_dwell_tc) begin
                    w_tt_nxt[r_vec] = i_y;
                    w_dwell_nxt     = '0;
                    if (w_last) begin
                        w_step_nxt  = '0;
                        w_vec_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_step_nxt  = w_step_inc;
                        w_vec_nxt   = w_vec_inc;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_vec         = r_vec;
    assign o_busy        = (r_state == S_APPLY);
    assign o_done        = (r_state == S_DONE);
    assign o_truth_table = r_tt;

endmodule
